// File: rtl/game_display_pkg.sv
// Shared geometry constants and board-nibble helpers for the 2048 display path.
package game_display_pkg;
  localparam int unsigned TILE_SIZE = 60;
  localparam int unsigned GAP       = 4;
  localparam int unsigned PITCH     = TILE_SIZE + GAP;
  localparam int unsigned BOARD_DIM = 4;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BOARD_W   = BOARD_DIM * BOARD_DIM * NIB_W;

  typedef logic [NIB_W-1:0]   nibble_t;
  typedef logic [BOARD_W-1:0] board_t;

  // Tile idx = row*4+col lives at bits [4*idx+3:4*idx].
  function automatic nibble_t get_tile(input board_t board, input logic [3:0] idx);
    return board[{idx, 2'b00} +: NIB_W];
  endfunction
endpackage

// File: rtl/board_tile_mapper_if.sv
// Scan-in / renderer-out signal bundle of the board tile mapper.
interface board_tile_mapper_if;
  import game_display_pkg::board_t;

  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       frame_start;
  board_t     board_in;
  logic       board_update;
  logic [3:0] tile_value;
  logic [5:0] tile_pos_x;
  logic [5:0] tile_pos_y;
  logic       in_tile_d;
  logic       in_board_d;
  logic       de_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       update_pending;

  modport master (
    output pix_x, pix_y, de_in, hsync_in, vsync_in, frame_start, board_in, board_update,
    input  tile_value, tile_pos_x, tile_pos_y, in_tile_d, in_board_d,
           de_out, hsync_out, vsync_out, update_pending
  );

  modport slave (
    input  pix_x, pix_y, de_in, hsync_in, vsync_in, frame_start, board_in, board_update,
    output tile_value, tile_pos_x, tile_pos_y, in_tile_d, in_board_d,
           de_out, hsync_out, vsync_out, update_pending
  );
endinterface

// File: rtl/delay_line.sv
// Fixed-depth shift register with a configurable reset pattern.
module delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sr <= RESET_VAL;
      else          sr <= din;
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sr <= {DEPTH{RESET_VAL}};
      else          sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/board_tile_mapper.sv
// Maps VGA scan coordinates onto the 4x4 board and feeds tile_renderer,
// with sync/flag delays matched to the renderer's registered output.
module board_tile_mapper #(
  parameter int unsigned BOARD_X0  = 200,
  parameter int unsigned BOARD_Y0  = 120,
  parameter int unsigned TILE_SIZE = game_display_pkg::TILE_SIZE,
  parameter int unsigned GAP       = game_display_pkg::GAP
) (
  input  logic                      clk,
  input  logic                      reset_n,
  board_tile_mapper_if.slave        bus
);
  import game_display_pkg::board_t;
  import game_display_pkg::get_tile;

  localparam int unsigned PITCH  = TILE_SIZE + GAP;
  localparam int unsigned EXTENT = 4 * PITCH - GAP;

  // Tile index along one axis from 3 pitch boundaries; valid only inside the board.
  function automatic logic [1:0] axis_idx(input logic [9:0] r);
    if (r >= 10'(3 * PITCH))      return 2'd3;
    else if (r >= 10'(2 * PITCH)) return 2'd2;
    else if (r >= 10'(PITCH))     return 2'd1;
    else                          return 2'd0;
  endfunction

  logic signed [10:0] rel_x, rel_y;
  logic [1:0]         col, row;
  logic [9:0]         off_x, off_y;
  logic               in_board, in_tile;

  always_comb begin
    rel_x    = $signed({1'b0, bus.pix_x} - 11'(BOARD_X0));
    rel_y    = $signed({1'b0, bus.pix_y} - 11'(BOARD_Y0));
    in_board = bus.de_in
             & ~rel_x[10] & (rel_x[9:0] < 10'(EXTENT))
             & ~rel_y[10] & (rel_y[9:0] < 10'(EXTENT));
    col      = axis_idx(rel_x[9:0]);
    row      = axis_idx(rel_y[9:0]);
    off_x    = rel_x[9:0] - ({8'd0, col} * 10'(PITCH));
    off_y    = rel_y[9:0] - ({8'd0, row} * 10'(PITCH));
    in_tile  = in_board & (off_x < 10'(TILE_SIZE)) & (off_y < 10'(TILE_SIZE));
  end

  // Board double buffer: active only ever changes on frame_start.
  board_t active_board, shadow_board;
  logic   pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_board <= '0;
      shadow_board <= '0;
      pending      <= 1'b0;
    end else begin
      if (bus.board_update) shadow_board <= bus.board_in;
      if (bus.board_update && bus.frame_start) begin
        active_board <= bus.board_in;
        pending      <= 1'b0;
      end else if (bus.board_update) begin
        pending      <= 1'b1;
      end else if (bus.frame_start && pending) begin
        active_board <= shadow_board;
        pending      <= 1'b0;
      end
    end
  end

  logic       s1_in_tile;
  logic [3:0] s1_idx;
  logic [5:0] s1_off_x, s1_off_y;
  logic [3:0] tile_value_q;
  logic [5:0] tile_pos_x_q, tile_pos_y_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_in_tile   <= 1'b0;
      s1_idx       <= '0;
      s1_off_x     <= '0;
      s1_off_y     <= '0;
      tile_value_q <= '0;
      tile_pos_x_q <= '0;
      tile_pos_y_q <= '0;
    end else begin
      s1_in_tile   <= in_tile;
      s1_idx       <= {row, col};
      s1_off_x     <= off_x[5:0];
      s1_off_y     <= off_y[5:0];
      tile_value_q <= s1_in_tile ? get_tile(active_board, s1_idx) : '0;
      tile_pos_x_q <= s1_in_tile ? s1_off_x : '0;
      tile_pos_y_q <= s1_in_tile ? s1_off_y : '0;
    end
  end

  logic [1:0] sync_d;
  logic [2:0] flag_d;

  delay_line #(.WIDTH(2), .DEPTH(3), .RESET_VAL(2'b11)) u_sync_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .din     ({bus.hsync_in, bus.vsync_in}),
    .dout    (sync_d)
  );

  delay_line #(.WIDTH(3), .DEPTH(3), .RESET_VAL(3'b000)) u_flag_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .din     ({bus.de_in, in_board, in_tile}),
    .dout    (flag_d)
  );

  assign bus.tile_value     = tile_value_q;
  assign bus.tile_pos_x     = tile_pos_x_q;
  assign bus.tile_pos_y     = tile_pos_y_q;
  assign bus.hsync_out      = sync_d[1];
  assign bus.vsync_out      = sync_d[0];
  assign bus.de_out         = flag_d[2];
  assign bus.in_board_d     = flag_d[1];
  assign bus.in_tile_d      = flag_d[0];
  assign bus.update_pending = pending;
endmodule

// File: doc/board_tile_mapper.md
Name: board_tile_mapper

Overview:
Upstream feeder for tile_renderer. Takes raw VGA scan coordinates, locates the pixel within the 4x4 2048 board, and drives tile_value, tile_pos_x and tile_pos_y from a frame-synchronous board snapshot. It also delays sync, data-enable and region flags so they line up with the renderer's registered pixel_color. A downstream mux uses the flags to pick renderer colour, gap colour or screen background.

Parameters:
BOARD_X0, 200, left pixel column of the board
BOARD_Y0, 120, top pixel row of the board
TILE_SIZE, 60, tile edge in pixels; must match the renderer's tile size
GAP, 4, spacing between tiles; PITCH = TILE_SIZE+GAP; board extent = 4*PITCH-GAP = 252 px

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
pix_x  in  10  current scan column
pix_y  in  10  current scan row
de_in  in  1  active-video qualifier for pix_x/pix_y
hsync_in  in  1  raw hsync
vsync_in  in  1  raw vsync
frame_start  in  1  one-cycle pulse at start of vertical blanking
board_in  in  64  16 tiles x 4 bits; tile idx=row*4+col occupies bits [4*idx+3:4*idx]
board_update  in  1  pulse: board_in is a new board state
tile_value  out  4  to tile_renderer
tile_pos_x  out  6  to tile_renderer, 0..59
tile_pos_y  out  6  to tile_renderer, 0..59
in_tile_d  out  1  pixel lies on a tile, aligned with renderer output
in_board_d  out  1  pixel lies within the board extent (tile or gap), aligned
de_out  out  1  de_in delayed, aligned
hsync_out  out  1  hsync_in delayed, aligned
vsync_out  out  1  vsync_in delayed, aligned
update_pending  out  1  a captured board is waiting for frame_start

Behaviour:
- Reset values:
  - active board, shadow board, update_pending: 0
  - tile_value, tile_pos_x, tile_pos_y, in_tile_d, in_board_d, de_out: 0
  - hsync_out, vsync_out: 1
  - all pipeline registers: 0, except sync pipeline registers, which reset to 1
- Reset mid-frame: outputs return to reset values immediately. The mapper resumes on the next de_in pixel after release, with no frame realignment required.
- Stage 1, registered:
  - rel_x = pix_x-BOARD_X0 and rel_y = pix_y-BOARD_Y0, computed at 11-bit signed width.
  - in_board = de_in & 0<=rel_x<252 & 0<=rel_y<252.
  - col/row are derived by comparing against 3 pitch boundaries (no divider/modulo operators).
  - off = rel - col*PITCH (constant multiply only).
  - in_tile = in_board & off_x<TILE_SIZE & off_y<TILE_SIZE.
- Stage 2, registered:
  - tile_value = active_board nibble[row*4+col] if in_tile, else 0.
  - tile_pos_x/y = off_x/off_y if in_tile, else 0.
- Latency:
  - pixel in cycle N -> tile_value/tile_pos valid at cycle N+2.
  - tile_renderer adds 1 cycle, so renderer output is at N+3.
  - de_out, hsync_out, vsync_out, in_tile_d, in_board_d carry the cycle-N values at cycle N+3 (3-stage shift).
- Board double buffering (no tearing):
  - board_update high: shadow <= board_in; update_pending <= 1. A later update before commit overwrites the shadow (last wins).
  - frame_start high with update_pending: active <= shadow; update_pending <= 0.
  - board_update and frame_start in the same cycle: active <= board_in directly; update_pending <= 0.
  - The active board never changes except on frame_start.
- Boundaries:
  - Pixel left/above the origin (rel negative) -> out of board.
  - rel = 251 -> in; rel = 252 -> out.
  - Gap columns/rows (off 60..63) -> in_board=1, in_tile=0.
  - de_in=0 forces both flags to 0 regardless of coordinates.

Decomposition:
- Shared package (game_display_pkg):
  - TILE_SIZE, GAP, PITCH, BOARD_DIM=4, board nibble width 4.
  - Function extracting a tile nibble from the 64-bit board.
- One natural sub-module: delay_line (parameter WIDTH, DEPTH, RESET_VAL) for the sync/flag shift registers.
- Everything else stays in this module.

Test Plan:
- Reset, then pixel (200,120) de_in=1 with board_in tile0=1 committed -> at +2 cycles tile_value=1, pos=(0,0); at +3 in_tile_d=1, in_board_d=1.
- Pixel (263,120) -> in_board_d=1, in_tile_d=0, tile_value=0. Pixel (264,184) -> tile idx 5 nibble, pos=(0,0).
- Pixel (451,371) -> tile 15, pos=(59,59). Pixel (452,120) and pixel (199,120) -> in_board_d=0.
- board_update with all-2s mid-frame -> update_pending=1 and output tile_value unchanged; frame_start -> next board pixel shows 2 and update_pending=0. Same-cycle update+frame_start -> new board used, pending stays 0.
- Toggle hsync_in/vsync_in/de_in patterns -> outputs reproduce them exactly 3 cycles later.
- Assert reset_n low mid-line -> outputs go to reset values at once, with syncs at 1. Release -> correct mapping from the next pixel, and active board reads all 0.
